// File: rtl/adder_hold_dec_adjust.sv
// Adder hold register (ADD) between the ALU and the special bus.
// Captures the raw ALU result and flags. In decimal mode it applies NMOS-6502
// style BCD correction over two extra cycles, one nibble per cycle.
// Ports:
//   clk, reset_n         clock, synchronous active-low reset
//   alu_in               raw ALU result
//   alu_carry            ALU carry out (subtract: 1 = no borrow)
//   alu_half_carry       ALU carry out of bit 3 (subtract: 1 = no borrow)
//   dec_en               decimal mode for this operation
//   sub_mode             1 = SBC correction, 0 = ADC correction
//   add_load             capture alu_in and flags on this edge
//   add_sb               request to drive the special bus
//   sb_out               special bus, driven only with a final result
//   carry_out            corrected carry, final while valid
//   valid                hold register holds a final result
//   busy                 decimal correction in progress
module adder_hold_dec_adjust #(
    parameter int unsigned      WIDTH  = 8,
    parameter int unsigned      LO_FIX = 6,
    parameter logic [WIDTH-1:0] HI_FIX = 8'h60
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] alu_in,
    input  logic             alu_carry,
    input  logic             alu_half_carry,
    input  logic             dec_en,
    input  logic             sub_mode,
    input  logic             add_load,
    input  logic             add_sb,
    output logic [WIDTH-1:0] sb_out,
    output logic             carry_out,
    output logic             valid,
    output logic             busy
);

    localparam int unsigned SUM_W = WIDTH + 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ADJ_LO = 2'd1;
    localparam logic [1:0] S_ADJ_HI = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             carry_q, carry_d;
    logic             hc_q, hc_d;
    logic             dec_q, dec_d;
    logic             sub_q, sub_d;
    logic             valid_q, busy_q;
    logic [SUM_W-1:0] lo_sum;

    // Low-nibble add correction; the extra bit catches overflow out of bit 7.
    assign lo_sum = {1'b0, hold_q} + SUM_W'(LO_FIX);

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        carry_d = carry_q;
        hc_d    = hc_q;
        dec_d   = dec_q;
        sub_d   = sub_q;

        if (add_load) begin
            // A load always wins and discards any correction in flight.
            hold_d  = alu_in;
            carry_d = alu_carry;
            hc_d    = alu_half_carry;
            dec_d   = dec_en;
            sub_d   = sub_mode;
            state_d = dec_en ? S_ADJ_LO : S_DONE;
        end else begin
            case (state_q)
                S_ADJ_LO: begin
                    if (dec_q) begin
                        if (!sub_q) begin
                            if (hc_q || (hold_q[3:0] > 4'd9)) begin
                                hold_d = lo_sum[WIDTH-1:0];
                                if (lo_sum[WIDTH]) begin
                                    carry_d = 1'b1;
                                end
                            end
                        end else if (!hc_q) begin
                            hold_d = hold_q - WIDTH'(LO_FIX);
                        end
                    end
                    state_d = S_ADJ_HI;
                end
                S_ADJ_HI: begin
                    if (dec_q) begin
                        if (!sub_q) begin
                            // Uses the value already fixed up by the low step.
                            if (carry_q || (hold_q[7:4] > 4'd9)) begin
                                hold_d  = hold_q + HI_FIX;
                                carry_d = 1'b1;
                            end
                        end else if (!carry_q) begin
                            hold_d = hold_q - HI_FIX;
                        end
                    end
                    state_d = S_DONE;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // State, datapath and status registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            hold_q  <= '0;
            carry_q <= 1'b0;
            hc_q    <= 1'b0;
            dec_q   <= 1'b0;
            sub_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            carry_q <= carry_d;
            hc_q    <= hc_d;
            dec_q   <= dec_d;
            sub_q   <= sub_d;
            valid_q <= (state_d == S_DONE);
            busy_q  <= (state_d == S_ADJ_LO) || (state_d == S_ADJ_HI);
        end
    end

    assign valid     = valid_q;
    assign busy      = busy_q;
    assign carry_out = carry_q;

    // Bus is only ever driven with a final value.
    assign sb_out = (add_sb && valid_q) ? hold_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_adder_hold_dec_adjust.sv
// Self-checking bench for adder_hold_dec_adjust: a result-level BCD model plus
// directed operations with hand-computed expected bytes.
module tb_adder_hold_dec_adjust;

    logic       clk = 1'b0;
    logic       reset_n, alu_carry, alu_half_carry, dec_en, sub_mode, add_load, add_sb;
    logic [7:0] alu_in;
    wire  [7:0] sb_out;
    logic       carry_out, valid, busy;

    int checks = 0;
    int errors = 0;
    bit compare_on = 1'b0;

    always #5 clk = ~clk;

    adder_hold_dec_adjust dut (
        .clk(clk), .reset_n(reset_n), .alu_in(alu_in), .alu_carry(alu_carry),
        .alu_half_carry(alu_half_carry), .dec_en(dec_en), .sub_mode(sub_mode),
        .add_load(add_load), .add_sb(add_sb), .sb_out(sb_out),
        .carry_out(carry_out), .valid(valid), .busy(busy)
    );

    // Model: final corrected result computed with integer arithmetic, plus
    // the number of correction cycles left (-1 = nothing loaded, 0 = final).
    int         m_left = -1;
    logic [7:0] m_val  = 8'h00;
    logic       m_carry = 1'b0;

    function automatic logic [8:0] bcd_final(input logic [7:0] a, input logic c,
                                             input logic hc, input logic dec,
                                             input logic sub);
        int v;
        int cy;
        logic [8:0] r;
        v  = int'(a);
        cy = c ? 1 : 0;
        if (dec && !sub) begin
            if (hc || (v % 16) > 9) begin
                v = v + 6;
                if (v > 255) begin
                    v  = v - 256;
                    cy = 1;
                end
            end
            if (cy == 1 || (v / 16) > 9) begin
                v  = (v + 96) % 256;
                cy = 1;
            end
        end else if (dec && sub) begin
            if (!hc) v = (v + 256 - 6) % 256;
            if (cy == 0) v = (v + 256 - 96) % 256;
        end
        r = {cy[0], v[7:0]};
        return r;
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            m_left <= -1;
        end else if (add_load) begin
            {m_carry, m_val} <= bcd_final(alu_in, alu_carry, alu_half_carry, dec_en, sub_mode);
            m_left <= dec_en ? 2 : 0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // An undriven bus reads as all-z, or as zero on a two-state simulator.
    task automatic chk_z(input string name);
        checks++;
        if (!(sb_out === 8'hzz || sb_out === 8'h00)) begin
            errors++;
            $display("FAIL %s: got %0h expected Z", name, sb_out);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (compare_on) begin
            chk("model_valid", 32'(valid), 32'(m_left == 0));
            chk("model_busy", 32'(busy), 32'(m_left > 0));
            if (m_left == 0) begin
                chk("model_carry", 32'(carry_out), 32'(m_carry));
                if (add_sb) chk("model_sb", 32'(sb_out), 32'(m_val));
                else        chk_z("model_sb_z");
            end else begin
                chk_z("model_sb_z");
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_load(input logic [7:0] a, input logic c, input logic hc,
                              input logic dec, input logic sub);
        alu_in = a; alu_carry = c; alu_half_carry = hc; dec_en = dec; sub_mode = sub;
        add_load = 1'b1;
        step();
        add_load = 1'b0;
        alu_in = 8'hA5; alu_carry = ~c; alu_half_carry = ~hc;
    endtask

    // Load one operation with the bus requested, wait for valid, check result.
    task automatic run_op(input string name, input logic [7:0] a, input logic c,
                          input logic hc, input logic dec, input logic sub,
                          input logic [7:0] exp_v, input logic exp_c, input int exp_busy);
        int nb;
        bit done;
        nb = 0;
        done = 1'b0;
        add_sb = 1'b1;
        drive_load(a, c, hc, dec, sub);
        for (int i = 0; i < 8 && !done; i++) begin
            if (valid) done = 1'b1;
            else begin
                if (busy) nb++;
                else chk_z({name, "_gap_z"});
                step();
            end
        end
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL %s_timeout: valid=0 after 8 cycles, expected 1", name);
        end else begin
            chk({name, "_sb"}, 32'(sb_out), 32'(exp_v));
            chk({name, "_carry"}, 32'(carry_out), 32'(exp_c));
            chk({name, "_busy_cycles"}, 32'(nb), 32'(exp_busy));
        end
    endtask

    initial begin
        reset_n = 1'b0; alu_in = 8'h00; alu_carry = 1'b0; alu_half_carry = 1'b0;
        dec_en = 1'b0; sub_mode = 1'b0; add_load = 1'b0; add_sb = 1'b1;
        step();
        step();
        compare_on = 1'b1;
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk_z("reset_sb_z");
        reset_n = 1'b1;
        step();

        run_op("bin_3c",   8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1, 0);
        run_op("dec_0a",   8'h0A, 1'b0, 1'b0, 1'b1, 1'b0, 8'h10, 1'b0, 2);
        run_op("dec_9a",   8'h9A, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 2);
        run_op("sub_0f",   8'h0F, 1'b1, 1'b0, 1'b1, 1'b1, 8'h09, 1'b1, 2);
        run_op("sub_ff",   8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 8'h99, 1'b0, 2);
        run_op("dec_hc",   8'h12, 1'b0, 1'b1, 1'b1, 1'b0, 8'h18, 1'b0, 2);
        run_op("dec_3c",   8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 8'h42, 1'b0, 2);
        run_op("dec_9e",   8'h9E, 1'b0, 1'b0, 1'b1, 1'b0, 8'h04, 1'b1, 2);
        run_op("dec_c_in", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h60, 1'b1, 2);
        run_op("sub_nofix",8'h45, 1'b1, 1'b1, 1'b1, 1'b1, 8'h45, 1'b1, 2);

        // Bus released while the result stays valid.
        add_sb = 1'b0;
        step();
        chk("idle_valid", 32'(valid), 32'd1);
        chk_z("sb_off_z");
        step();

        // Restart: binary load during ADJ_LO replaces the decimal operation.
        add_sb = 1'b1;
        drive_load(8'h9A, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("restart_busy", 32'(busy), 32'd1);
        drive_load(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("restart_valid", 32'(valid), 32'd1);
        chk("restart_sb", 32'(sb_out), 32'h55);
        step();

        // Reset during ADJ_HI aborts the correction.
        drive_load(8'h9A, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        chk("abort_busy_hi", 32'(busy), 32'd1);
        reset_n = 1'b0;
        step();
        chk("abort_valid", 32'(valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk_z("abort_sb_z");
        reset_n = 1'b1;
        step();
        step();
        chk("post_reset_valid", 32'(valid), 32'd0);

        // Reset has priority over a simultaneous load.
        alu_in = 8'h77; dec_en = 1'b0; add_load = 1'b1; reset_n = 1'b0;
        step();
        add_load = 1'b0; reset_n = 1'b1;
        chk("reset_vs_load_valid", 32'(valid), 32'd0);
        step();

        compare_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_hold_dec_adjust.md
Name: adder_hold_dec_adjust

Overview:
Adder hold register (ADD) between the ALU and the special bus, directly upstream of the accumulator.
- Latches the raw ALU result and flags.
- In decimal mode, applies NMOS-6502-style BCD correction over two extra clock cycles.
- Drives the corrected byte onto the special bus under control, where the accumulator loads it.
- Supplies the decimal-corrected carry to the flag logic.

Parameters:
- WIDTH, 8, datapath width; correction logic is defined for 8 only, two nibbles.
- LO_FIX, 6, low-nibble correction constant.
- HI_FIX, 8'h60, high-nibble correction constant.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  synchronous active-low reset.
- alu_in  input  8  raw ALU result.
- alu_carry  input  1  ALU carry out; for subtract, 1 = no borrow.
- alu_half_carry  input  1  ALU carry out of bit 3; for subtract, 1 = no borrow.
- dec_en  input  1  decimal mode (D flag AND decimal-capable opcode).
- sub_mode  input  1  1 = subtract (SBC) correction, 0 = add (ADC) correction.
- add_load  input  1  capture alu_in/flags this edge.
- add_sb  input  1  drive special bus with hold register.
- sb_out  output  8  special bus output, tri-state.
- carry_out  output  1  corrected carry for the C flag.
- valid  output  1  hold register contains a final result.
- busy  output  1  correction in progress.

Behaviour:
Interface: one clock; reset is synchronous and active-low.

Reset (reset_n=0 at edge):
- hold=0, carry_l=0, hc_l=0, dec_l=0, sub_l=0, state=IDLE.
- valid=0, busy=0, sb_out=Z.
- Reset has priority over add_load and aborts any correction in progress.

States:
- IDLE, ADJ_LO, ADJ_HI, DONE.
- valid=1 only in DONE; busy=1 in ADJ_LO and ADJ_HI.

add_load=1 in any state (reset inactive):
- hold<=alu_in, carry_l<=alu_carry, hc_l<=alu_half_carry, dec_l<=dec_en, sub_l<=sub_mode.
- Next state is ADJ_LO if dec_en, else DONE.
- A load during ADJ_LO or ADJ_HI abandons the old operation and restarts. No partial correction of the old value is retained.

ADJ_LO, add (sub_l=0):
- Condition: hc_l OR hold[3:0]>9.
- If met: hold<=hold+6 (8-bit wrap). If that addition overflows bit 7, carry_l<=1.
- Next state ADJ_HI.

ADJ_LO, subtract (sub_l=1):
- If hc_l=0: hold<=hold-6 (8-bit wrap).
- carry_l unchanged. Next state ADJ_HI.

ADJ_HI, add:
- Condition: carry_l OR hold[7:4]>9, using the post-ADJ_LO value.
- If met: hold<=hold+8'h60 (wrap) and carry_l<=1.
- Next state DONE.

ADJ_HI, subtract:
- If carry_l=0: hold<=hold-8'h60 (wrap).
- carry_l unchanged. Next state DONE.

DONE:
- Holds value indefinitely until the next add_load or reset.

Latency:
- Binary: valid=1 the cycle after the add_load edge.
- Decimal: valid=1 three cycles after the add_load edge.
- The hold register never changes without add_load or a correction step.

Outputs:
- carry_out = carry_l, registered. It is final only when valid=1.
- sb_out = hold when add_sb=1 AND valid=1, else 8'bZ. The bus is never driven with a partially corrected value.
- add_sb asserted while busy: output stays Z. This is not an error, and the caller must wait for valid.

Simultaneous add_load and add_sb:
- sb_out reflects the register state before the edge.
- After the edge, valid follows the new load rules.

Test Plan:
1. Binary: reset, alu_in=8'h3C, carry=1, dec_en=0, add_load one cycle, add_sb=1 -> next cycle valid=1, sb_out=8'h3C, carry_out=1, busy never asserted.
2. Decimal add: alu_in=8'h0A (09+01), hc=0, c=0, dec_en=1, sub_mode=0 -> busy 2 cycles, then valid=1, sb_out=8'h10, carry_out=0.
3. Decimal add with wrap: alu_in=8'h9A (99+01), hc=0, c=0 -> after ADJ_LO hold=8'hA0, final sb_out=8'h00, carry_out=1.
4. Decimal subtract: alu_in=8'h0F (10-01), hc=0, c=1, sub_mode=1 -> final sb_out=8'h09, carry_out=1. Also alu_in=8'hFF (00-01), hc=0, c=0 -> sb_out=8'h99, carry_out=0.
5. Restart and reset: decimal load 8'h9A, new binary add_load 8'h55 during ADJ_LO -> next cycle valid=1, sb_out=8'h55. Repeat with reset_n=0 during ADJ_HI -> valid=0, sb_out=Z, hold=0.
6. Bus gating: add_sb=1 held throughout a decimal operation -> sb_out=Z while busy, corrected value appears exactly on the first valid cycle. add_sb=0 -> Z.
